instr_fetch_buffer: RTL

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues one-bundle fetch requests and queues the responses in a DEPTH-entry FIFO.
// Optional stall counter output enabled by defining IFB_PERF_CNT_EN.
module instr_fetch_buffer #(
    parameter int ADDR_W  = 8,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [FETCH_W*32-1:0]  mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FETCH_W*32-1:0]  out_instr,
    output logic [ADDR_W-1:0]      out_pc
`ifdef IFB_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = FETCH_W * 32;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(FETCH_W);

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   instr_q [DEPTH];
    logic [DATA_W-1:0]   instr_d [DEPTH];
    logic [ADDR_W-1:0]   pc_q [DEPTH];
    logic [ADDR_W-1:0]   pc_d [DEPTH];

    logic credit_ok;
    logic push;
    logic pop;

    // Credits count the inflight response so a returning bundle always has a free slot.
    always_comb begin
        credit_ok = (count_q + CNT_W'(inflight_q)) < DEPTH_C;
        mem_req   = (state_q == FETCH) && enable && !redirect && credit_ok;
        mem_addr  = fetch_pc_q;
        out_valid = (count_q != '0) && !redirect;
        out_instr = instr_q[rd_ptr_q];
        out_pc    = pc_q[rd_ptr_q];
        push      = inflight_q && !redirect;
        pop       = out_valid && out_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = FETCH;
            FETCH:   if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every _d signal takes its _q value first, so no path through this block leaves it unassigned (no latch).
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        instr_d       = instr_q;
        pc_d          = pc_q;

        if (redirect) begin
            // Flush: the inflight response is dropped by simply never pushing it.
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = mem_req;
            if (mem_req) begin
                fetch_pc_d    = fetch_pc_q + PC_STEP;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                instr_d[wr_ptr_q] = mem_rdata;
                pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: the bundle storage is reset as well, so out_instr/out_pc read zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                pc_q[i]    <= pc_d[i];
            end
        end
    end

`ifdef IFB_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == FETCH) && enable && !redirect && !credit_ok && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
